// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the host byte stream and the instruction-RAM byte write port of the
//   instruction-memory loader.
//
//   Stream (host -> loader):
//     in_valid  in_data holds a byte
//     in_data   stream byte
//     in_ready  loader accepts a byte this cycle
//   RAM write port (loader -> RAM):
//     wr_en     byte write strobe, one cycle per byte
//     wr_addr   byte address
//     wr_data   byte to write
//
//   Modports:
//     slave   the loader (sinks the stream, drives the RAM write port)
//     master  the environment (host link and RAM)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the byte-addressed instruction memory. Receives a framed
//   byte stream  SYNC_BYTE, len, payload[len], checksum  and writes each
//   payload byte into instruction RAM, one byte per write. The CPU is held in
//   reset (cpu_hold) until a frame arrives whose payload plus checksum sums to
//   zero modulo 256.
//
//   Parameters:
//     SYNC_BYTE  frame start marker
//     ADDR_W     instruction-memory byte-address width
//     BASE_ADDR  byte address of the first payload byte
//
//   Ports:
//     clk         system clock, rising edge
//     rst_n       asynchronous reset, active-low
//     start       1-cycle pulse, re-arms the loader from DONE or ERR
//     bus         stream + RAM write port (imem_loader_if.slave)
//     cpu_hold    1 = keep CPU/PC in reset
//     done        sticky, load completed with good checksum
//     err         sticky, checksum mismatch
//     byte_count  payload bytes written so far in the current frame
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter logic [7:0]        SYNC_BYTE = 8'hA5,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  // A length byte of zero stands for a full 2^ADDR_W-byte image, which needs
  // one more bit than the address; len_q and byte_count_q carry that bit.
  localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              in_ready;
  logic              accept;
  logic [ADDR_W:0]   count_inc;
  logic              last_byte;
  logic [7:0]        csum_total;
  logic              csum_ok;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign accept     = bus.in_valid && in_ready;
  assign count_inc  = byte_count_q + (ADDR_W+1)'(1);
  assign last_byte  = (count_inc == len_q);
  assign csum_total = sum_q + bus.in_data;
  assign csum_ok    = (csum_total == 8'h00);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the clock edge regardless of the
  // order the always_ff blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb assigns a default to everything it drives before
  // any branch, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // Anything other than the marker is line noise and is dropped.
        if (accept && (bus.in_data == SYNC_BYTE)) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) state_d = S_DATA;
      end
      S_DATA: begin
        if (accept && last_byte) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_d = csum_ok ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready     = 1'b0;
    sum_d        = sum_q;
    len_d        = len_q;
    byte_count_d = byte_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = done_q;
    err_d        = err_q;
    cpu_hold_d   = cpu_hold_q;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        sum_d    = 8'h00;
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d        = (bus.in_data == 8'h00) ? LEN_FULL
                                                : (ADDR_W+1)'(bus.in_data);
          byte_count_d = '0;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (accept) begin
          // The write is registered: the strobe appears the cycle after the
          // byte is accepted. The address add truncates to ADDR_W bits, so
          // loads running past the top of memory wrap to zero.
          wr_en_d      = 1'b1;
          wr_addr_d    = BASE_ADDR + byte_count_q[ADDR_W-1:0];
          wr_data_d    = bus.in_data;
          sum_d        = csum_total;
          byte_count_d = count_inc;
        end
      end
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) begin
          if (csum_ok) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d      = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q        <= 8'h00;
      len_q        <= '0;
      byte_count_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      sum_q        <= sum_d;
      len_q        <= len_d;
      byte_count_q <= byte_count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign byte_count   = byte_count_q;

endmodule
